// File: rtl/four_n_bits_rr_mux_module_pkg.sv
// Purpose: source-select encoding shared between the 1-to-4 demux and the 4-to-1 round-robin mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package four_n_bits_rr_mux_module_pkg;

  // Two-bit channel index: 00=A, 01=B, 10=C, 11=D.
  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

  // Next priority position after serving index k; the 2-bit add wraps D back to A.
  function automatic sel_t sel_next(input sel_t k);
    return k + sel_t'(1);
  endfunction

endpackage

// File: rtl/four_n_bits_rr_mux_module_arbiter.sv
// Purpose: combinational 4-way round-robin grant, searching REQ upward from PTR modulo 4.
// Latency: 0 cycles (pure combinational).
// Backpressure: none here; the caller qualifies GRANT with its own load enable.
module four_rr_arbiter_module
  import four_n_bits_rr_mux_module_pkg::*;
(
  input  logic [3:0] REQ,
  input  sel_t       PTR,
  output logic [3:0] GRANT,
  output sel_t       GRANT_IDX
);

  // First requester at or after PTR wins; GRANT stays zero when nobody requests.
  always_comb begin
    sel_t k;
    logic found;
    GRANT     = 4'b0000;
    GRANT_IDX = PTR;
    found     = 1'b0;
    k         = PTR;
    for (int i = 0; i < 4; i++) begin
      k = PTR + sel_t'(i);
      if (!found && REQ[k]) begin
        GRANT[k]  = 1'b1;
        GRANT_IDX = k;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/four_n_bits_rr_mux_module.sv
// Purpose: merge four BITS-wide valid/ready sources into one registered output via round-robin.
// Latency: 1 cycle from input handshake to OUT_VALID.
// Backpressure: READY is all-zero while the output word is held (OUT_VALID && !OUT_READY).
module four_n_bits_rr_mux_module
  import four_n_bits_rr_mux_module_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  input  logic [BITS-1:0] C,
  input  logic [BITS-1:0] D,
  input  logic [3:0]      VALID,
  output logic [3:0]      READY,
  output logic [BITS-1:0] OUT_DATA,
  output logic [1:0]      OUT_SELECT,
  output logic            OUT_VALID,
  input  logic            OUT_READY
);

  logic [BITS-1:0] out_dat_q, out_dat_d;
  sel_t            out_sel_q, out_sel_d;
  logic            out_vld_q, out_vld_d;
  sel_t            ptr_q, ptr_d;

  logic [3:0]      grant;
  sel_t            grant_idx;
  logic [BITS-1:0] mux_dat;
  logic            load_en;
  logic            xfer;

  four_rr_arbiter_module u_arb (
    .REQ       (VALID),
    .PTR       (ptr_q),
    .GRANT     (grant),
    .GRANT_IDX (grant_idx)
  );

  // Per-bit 4:1 selection of the granted source.
  for (genvar b = 0; b < BITS; b++) begin : g_mux
    logic [3:0] col;
    assign col        = {D[b], C[b], B[b], A[b]};
    assign mux_dat[b] = col[grant_idx];
  end

  // The single output slot can take a word when empty or when it drains this cycle.
  always_comb begin
    load_en = !out_vld_q || OUT_READY;
    READY   = 4'b0000;
    if (!RST && load_en) begin
      READY = grant;
    end
    xfer = |READY;
  end

  // Next state: load on a handshake, clear valid on a drain with nothing to load, else hold.
  always_comb begin
    out_dat_d = out_dat_q;
    out_sel_d = out_sel_q;
    out_vld_d = out_vld_q;
    ptr_d     = ptr_q;
    if (xfer) begin
      out_dat_d = mux_dat;
      out_sel_d = grant_idx;
      out_vld_d = 1'b1;
      ptr_d     = sel_next(grant_idx);
    end else if (load_en) begin
      out_vld_d = 1'b0;
    end
  end

  // State registers; reset discards any pending word and restores A as highest priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_dat_q <= '0;
      out_sel_q <= SEL_A;
      out_vld_q <= 1'b0;
      ptr_q     <= SEL_A;
    end else begin
      out_dat_q <= out_dat_d;
      out_sel_q <= out_sel_d;
      out_vld_q <= out_vld_d;
      ptr_q     <= ptr_d;
    end
  end

  assign OUT_DATA   = out_dat_q;
  assign OUT_SELECT = out_sel_q;
  assign OUT_VALID  = out_vld_q;

endmodule

// File: tb/tb_four_n_bits_rr_mux_module.sv
// Purpose: directed self-checking bench for the 4-source round-robin mux.
// Latency: inputs change 1 time unit after each rising edge; checks happen 1 unit later.
// Backpressure: OUT_READY is driven low for several cycles in the backpressure phase.
module tb_four_n_bits_rr_mux_module;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] A, B, C, D;
  logic [3:0] VALID;
  logic [3:0] READY;
  logic [3:0] OUT_DATA;
  logic [1:0] OUT_SELECT;
  logic       OUT_VALID;
  logic       OUT_READY;

  int n_tests = 0;
  int n_fail  = 0;

  four_n_bits_rr_mux_module #(.BITS(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .VALID      (VALID),
    .READY      (READY),
    .OUT_DATA   (OUT_DATA),
    .OUT_SELECT (OUT_SELECT),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Check the registered output word.
  task automatic chk_out(input string tag, input logic vld, input logic [1:0] sel,
                         input logic [3:0] dat);
    chk({tag, "_vld"}, 32'(OUT_VALID), 32'(vld));
    chk({tag, "_sel"}, 32'(OUT_SELECT), 32'(sel));
    chk({tag, "_dat"}, 32'(OUT_DATA), 32'(dat));
  endtask

  logic [3:0] fair_dat [5];
  logic [1:0] fair_sel [5];
  logic [3:0] fair_rdy [5];

  initial begin
    fair_dat = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    fair_sel = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    fair_rdy = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    // Reset held two cycles with every source requesting.
    RST = 1'b1; VALID = 4'b1111; OUT_READY = 1'b1;
    A = 4'h1; B = 4'h2; C = 4'h3; D = 4'h4;
    #1;
    chk("rst_ready0", 32'(READY), 32'h0);
    cyc();
    chk("rst_ready1", 32'(READY), 32'h0);
    cyc();
    chk("rst_ready2", 32'(READY), 32'h0);
    chk_out("rst_out", 1'b0, 2'b00, 4'h0);

    // Release: A has priority first, then round-robin over all four.
    RST = 1'b0;
    #1;
    chk("first_grant", 32'(READY), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_out($sformatf("fair%0d", i), 1'b1, fair_sel[i], fair_dat[i]);
      chk($sformatf("fair%0d_rdy", i), 32'(READY), 32'(fair_rdy[i]));
    end

    // Single source C (pointer now at B).
    VALID = 4'b0100; C = 4'hC;
    #1;
    chk("single_rdy", 32'(READY), 32'b0100);
    cyc();
    chk_out("single", 1'b1, 2'b10, 4'hC);

    // Backpressure: output held three cycles, A waiting.
    OUT_READY = 1'b0; VALID = 4'b0001; A = 4'h5;
    #1;
    chk("bp_rdy", 32'(READY), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("bp%0d_rdy", i), 32'(READY), 32'h0);
      chk_out($sformatf("bp%0d", i), 1'b1, 2'b10, 4'hC);
    end
    // Drain and load together: pointer at D, search wraps to A.
    OUT_READY = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(READY), 32'b0001);
    cyc();
    chk_out("bp_reload", 1'b1, 2'b00, 4'h5);

    // Drain with nothing to load: valid drops, data and select hold.
    VALID = 4'b0000;
    #1;
    chk("idle_rdy", 32'(READY), 32'h0);
    cyc();
    chk_out("idle", 1'b0, 2'b00, 4'h5);

    // Wrap: serve D (pointer returns to A), then A beats D.
    VALID = 4'b1000; D = 4'h9;
    #1;
    chk("wrapD_rdy", 32'(READY), 32'b1000);
    cyc();
    chk_out("wrapD", 1'b1, 2'b11, 4'h9);
    VALID = 4'b1001; A = 4'h6;
    #1;
    chk("wrapA_rdy", 32'(READY), 32'b0001);
    cyc();
    chk_out("wrapA", 1'b1, 2'b00, 4'h6);
    chk("wrapD2_rdy", 32'(READY), 32'b1000);
    cyc();
    chk_out("wrapD2", 1'b1, 2'b11, 4'h9);

    // Serve B so the pointer sits at C, then reset mid-operation.
    VALID = 4'b0010; B = 4'h7;
    cyc();
    chk_out("pre_rst", 1'b1, 2'b01, 4'h7);
    RST = 1'b1; VALID = 4'b1111;
    #1;
    chk("midrst_rdy", 32'(READY), 32'h0);
    cyc();
    chk_out("midrst", 1'b0, 2'b00, 4'h0);
    RST = 1'b0;
    #1;
    chk("midrst_ptr", 32'(READY), 32'b0001);
    cyc();
    chk_out("post_rst", 1'b1, 2'b00, 4'h6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
